div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit radix-2 restoring divider serving as responder to the execute stage for DIV/DIVU.
- Execute stage issues a request (start_i plus operands) and holds it, stalling the pipeline, until ready_o; execute stage then writes result_o into HI/LO.
- annul_i lets the execute stage cancel an in-flight division, e.g. on flush.
- One division in flight at a time; no internal queueing.

Parameters:
- DATA_W, 32, operand width; result width is 2*DATA_W.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  input  32  dividend.
- opdata2_i  input  32  divisor.
- start_i  input  1  request; held high by requester until it has consumed ready_o.
- annul_i  input  1  cancel current operation.
- result_o  output  64  {remainder[63:32], quotient[31:0]}, registered.
- ready_o  output  1  result valid, registered.

Behaviour:
- Reset (rst=1 on an edge): state=IDLE, cnt=0, internal dividend register=0; result_o=0, ready_o=0. Reset mid-operation aborts immediately; no result is produced.
- States: IDLE, BYZERO, ON, END.
- IDLE, start_i=1 and annul_i=0:
  - Latch signed_div_i and the sign bits of both operands.
  - If opdata2_i==0, go to BYZERO.
  - Otherwise latch |op1| and |op2|. Two's-complement negate an operand only when signed and its bit 31=1. Load 65-bit dividend register = {32'b0, |op1|, 1'b0}, cnt=0, go to ON.
- IDLE, start_i=0 or annul_i=1: stay in IDLE, outputs stay 0.
- BYZERO: dividend register=0, go to END. Annul in BYZERO goes to IDLE.
- ON, annul_i=1: go to IDLE, cnt=0, outputs stay 0. Annul has priority over iteration.
- ON, cnt<32, one iteration per edge:
  - diff = {1'b0, dreg[63:32]} - {1'b0, divisor} (33-bit).
  - If diff[32]=1 (negative): dreg <= {dreg[63:0], 1'b0}.
  - Else: dreg <= {diff[31:0], dreg[31:0], 1'b1}.
  - cnt <= cnt+1.
- ON, cnt==32 (finalize edge), then go to END:
  - Quotient = dreg[31:0], negated if signed and sign1 XOR sign2.
  - Remainder = dreg[64:33], negated if signed and sign1 (remainder takes the dividend's sign).
  - Store both in dreg.
- END, start_i=1: result_o <= {rem, quo}, ready_o <= 1, stay in END.
- END, start_i=0: result_o <= 0, ready_o <= 0, go to IDLE, cnt=0.
- Latency from edge E0 where start is sampled in IDLE:
  - Nonzero divisor: iterations on E1..E32, finalize on E33, ready_o=1 after E34.
  - Zero divisor: BYZERO on E0, END on E1, ready_o=1 with result_o=0 after E2.
- ready_o stays high while start_i stays high. A new request requires start_i low for at least one cycle (END -> IDLE).
- Signed overflow 0x80000000 / -1 wraps: quotient=0x80000000, remainder=0. No trap is raised.
- Operand changes after E0 are ignored; only latched values are used.
- Arithmetic is modulo 2^32 per half. No X propagation; all registers are defined from reset.

Test Plan:
- Unsigned 100/7, start held high -> ready_o rises after E34, result_o=0x00000002_0000000E; drop start -> ready_o=0 and result_o=0 next edge.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD; signed 7/-2 -> 0x00000001_FFFFFFFD.
- Divide by zero 5/0 -> ready_o after E2, result_o=0; followed immediately by 9/3 -> 0x00000000_00000003 after 34 edges.
- Annul at E10 of 1000/3 -> state returns to IDLE, ready_o never asserts; restart 1000/3 -> 0x00000001_0000014D.
- Signed 0x80000000 / 0xFFFFFFFF -> 0x00000000_80000000; unsigned 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF; unsigned 0xFFFFFFFF/0x10 -> 0x0000000F_0FFFFFFF.
- rst asserted at E20 of an operation -> all outputs 0 next edge; no spurious ready_o afterwards with start_i low.

Source files
------------

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage (master) and the divider (slave).
interface div_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; one division in flight,
// result {remainder, quotient} held while the requester keeps start_i high.
module div_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input logic        clk,
  input logic        rst,
  div_unit_if.slave  bus
);

  localparam int unsigned DREG_W = 2 * DATA_W + 1;

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

  state_t              state_q, state_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic [DREG_W-1:0]   dreg_q, dreg_nxt;
  logic [DATA_W-1:0]   divisor_q, divisor_nxt;
  logic                signed_q, signed_nxt;
  logic                sign1_q, sign1_nxt;
  logic                sign2_q, sign2_nxt;
  logic [2*DATA_W-1:0] result_q, result_nxt;
  logic                ready_q, ready_nxt;

  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   op1_abs, op2_abs, quo_fin, rem_fin, quo_raw, rem_raw;

  // Magnitudes of the incoming operands; only negated for signed requests
  assign op1_abs = (bus.signed_div_i && bus.opdata1_i[DATA_W-1])
                   ? (~bus.opdata1_i) + DATA_W'(1) : bus.opdata1_i;
  assign op2_abs = (bus.signed_div_i && bus.opdata2_i[DATA_W-1])
                   ? (~bus.opdata2_i) + DATA_W'(1) : bus.opdata2_i;

  assign diff    = {1'b0, dreg_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};

  // Sign fix-up: quotient negative on differing signs, remainder follows the dividend
  assign quo_raw = dreg_q[DATA_W-1:0];
  assign rem_raw = dreg_q[2*DATA_W:DATA_W+1];
  assign quo_fin = (signed_q && (sign1_q ^ sign2_q)) ? (~quo_raw) + DATA_W'(1) : quo_raw;
  assign rem_fin = (signed_q && sign1_q) ? (~rem_raw) + DATA_W'(1) : rem_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dreg_q    <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      dreg_q    <= dreg_nxt;
      divisor_q <= divisor_nxt;
      signed_q  <= signed_nxt;
      sign1_q   <= sign1_nxt;
      sign2_q   <= sign2_nxt;
      result_q  <= result_nxt;
      ready_q   <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    dreg_nxt    = dreg_q;
    divisor_nxt = divisor_q;
    signed_nxt  = signed_q;
    sign1_nxt   = sign1_q;
    sign2_nxt   = sign2_q;
    result_nxt  = '0;
    ready_nxt   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          signed_nxt = bus.signed_div_i;
          sign1_nxt  = bus.opdata1_i[DATA_W-1];
          sign2_nxt  = bus.opdata2_i[DATA_W-1];
          if (bus.opdata2_i == '0) begin
            state_nxt = BYZERO;
          end else begin
            divisor_nxt = op2_abs;
            dreg_nxt    = {DATA_W'(0), op1_abs, 1'b0};
            cnt_nxt     = '0;
            state_nxt   = ON;
          end
        end
      end

      BYZERO: begin
        if (bus.annul_i) begin
          state_nxt = IDLE;
        end else begin
          dreg_nxt  = '0;
          state_nxt = END;
        end
      end

      ON: begin
        if (bus.annul_i) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt_q != CNT_W'(DATA_W)) begin
          // Restore-or-subtract step; quotient bits shift in from the bottom
          if (diff[DATA_W])
            dreg_nxt = {dreg_q[2*DATA_W-1:0], 1'b0};
          else
            dreg_nxt = {diff[DATA_W-1:0], dreg_q[DATA_W-1:0], 1'b1};
          cnt_nxt = cnt_q + CNT_W'(1);
        end else begin
          dreg_nxt  = {1'b0, rem_fin, quo_fin};
          state_nxt = END;
        end
      end

      END: begin
        if (bus.start_i) begin
          result_nxt = dreg_q[2*DATA_W-1:0];
          ready_nxt  = 1'b1;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboarded divisions, latency, annul and reset.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  div_unit_if #(.DATA_W(32)) bus ();

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Independent reference: language division with the overflow case pinned
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Issue one request, wait for ready with a bound, check latency/result/hold/drop
  task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res);
    int lat;
    logic [63:0] exp_v;
    logic [63:0] got;
    int exp_lat;
    exp_lat = (b == 32'd0) ? 3 : 35;
    exp_q.push_back(exp_res);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      if (k == 1) begin
        #1;
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = ~sgn;
      end
      @(negedge clk);
      if (bus.ready_o === 1'b1) begin
        lat = k;
        break;
      end
    end
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (lat !== exp_lat)
      $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, exp_lat);
    else pass_cnt++;
    got = bus.result_o;
    total_cnt++;
    if (got !== exp_v)
      $display("FAIL %s result: got %h, expected %h", name, got, exp_v);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== exp_v)
      $display("FAIL %s hold: ready=%b result=%h, expected ready=1 result=%h",
               name, bus.ready_o, bus.result_o, exp_v);
    else pass_cnt++;
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0)
      $display("FAIL %s drop: ready=%b result=%h, expected ready=0 result=0",
               name, bus.ready_o, bus.result_o);
    else pass_cnt++;
  endtask

  // Watch for a spurious ready over a window with start_i low
  task automatic expect_quiet(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) seen = 1'b1;
    end
    total_cnt++;
    if (seen)
      $display("FAIL %s quiet: outputs became nonzero, expected ready=0 result=0", name);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (bus.ready_o !== 1'b0) $display("FAIL reset ready: got %b, expected 0", bus.ready_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.result_o !== 64'd0) $display("FAIL reset result: got %h, expected 0", bus.result_o);
    else pass_cnt++;
    rst = 1'b0;
    expect_quiet("post_reset", 5);
  endtask

  task automatic test_unsigned();
    run_op("u100_7", 1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
    run_op("uFFFF_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF);
    run_op("uFFFF_10", 1'b0, 32'hFFFF_FFFF, 32'h10, 64'h0000_000F_0FFF_FFFF);
  endtask

  task automatic test_signed();
    run_op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
  endtask

  task automatic test_div_zero();
    run_op("z5_0", 1'b0, 32'd5, 32'd0, 64'd0);
    run_op("u9_3", 1'b0, 32'd9, 32'd3, 64'h0000_0000_0000_0003);
  endtask

  task automatic test_annul();
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    expect_quiet("annul", 40);
    run_op("u1000_3", 1'b0, 32'd1000, 32'd3, 64'h0000_0001_0000_014D);
  endtask

  task automatic test_reset_mid_op();
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd12345;
    bus.opdata2_i    = 32'd17;
    bus.start_i      = 1'b1;
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0)
      $display("FAIL rst_mid: ready=%b result=%h, expected 0/0", bus.ready_o, bus.result_o);
    else pass_cnt++;
    rst = 1'b0;
    expect_quiet("rst_mid", 40);
    run_op("after_rst", 1'b0, 32'd12345, 32'd17, model(1'b0, 32'd12345, 32'd17));
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic s;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
      s = 1'(i % 2);
      run_op("rand", s, a, b, model(s, a, b));
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
